// File: rtl/cache_axi_bridge_if.sv
// AXI3 master-side bus bundle for cache_axi_bridge.
// The bridge connects through the master modport; the crossbar or a bench
// model connects through the slave modport.
interface cache_axi_bridge_if;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    // Write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI3 bridge: one transaction at a time, either a full-line burst
// (fill or write-back) or a single uncached beat with byte strobes.
// Optional feature macro: CACHE_AXI_WRAP_EN selects critical-word-first WRAP
// bursts for cached lines; without it cached bursts are line-aligned INCR.
module cache_axi_bridge #(
    parameter logic ID         = 1'b0,
    parameter int   LINE_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req,
    input  logic                          wr,
    input  logic                          uncached,
    input  logic [31:0]                   addr,
    input  logic [3:0]                    wstrb_in,
    input  logic [31:0]                   wdata_in,
    output logic [31:0]                   rdata_out,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic                          addr_ok,
    output logic                          data_ok,
    output logic                          done,
    output logic                          err,
    cache_axi_bridge_if.master            axi
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST_LINE_BEAT = CW'(LINE_WORDS - 1);
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q;
    logic          unc_q;
    logic [3:0]    strb_q;
    logic [CW-1:0] start_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Transaction-shape values derived from the latched request
    logic [31:0]   bus_addr;
    logic [3:0]    bus_len;
    logic [1:0]    bus_burst;
    logic [CW-1:0] last_beat;
    logic          accept;

    assign accept    = (state_q == S_IDLE) && req;
    assign last_beat = unc_q ? '0 : LAST_LINE_BEAT;
    assign bus_len   = unc_q ? 4'd0 : 4'(LINE_WORDS - 1);

`ifdef CACHE_AXI_WRAP_EN
    // Critical word first: start at the requested word and wrap in the line
    assign bus_addr  = unc_q ? addr_q : {addr_q[31:2], 2'b00};
    assign bus_burst = unc_q ? BURST_INCR : BURST_WRAP;
    assign beat_idx  = unc_q ? '0 : start_q + cnt_q;
`else
    // Line-aligned incrementing burst; beat index is simply the beat count
    assign bus_addr  = unc_q ? addr_q : {addr_q[31:CW+2], {(CW+2){1'b0}}};
    assign bus_burst = BURST_INCR;
    assign beat_idx  = unc_q ? '0 : cnt_q;
`endif

    // Fixed AXI attribute fields and pass-through data
    assign axi.arid    = {3'b000, ID};
    assign axi.awid    = {3'b000, ID};
    assign axi.wid     = {3'b000, ID};
    assign axi.arprot  = {2'b00, ID};
    assign axi.awprot  = {2'b00, ID};
    assign axi.arsize  = 3'b010;
    assign axi.awsize  = 3'b010;
    assign axi.arlock  = 2'b00;
    assign axi.awlock  = 2'b00;
    assign axi.arcache = 4'h0;
    assign axi.awcache = 4'h0;
    assign axi.arlen   = bus_len;
    assign axi.awlen   = bus_len;
    assign axi.arburst = bus_burst;
    assign axi.awburst = bus_burst;
    assign axi.wdata   = wdata_in;
    assign axi.wstrb   = unc_q ? strb_q : 4'hF;
    assign rdata_out   = axi.rdata;

    // IDs and the low response bit carry nothing the bridge acts on
    logic unused_inputs;
    assign unused_inputs = ^{axi.rid, axi.bid, axi.rresp[0], axi.bresp[0]};

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and per-state handshake outputs
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        axi.arvalid = 1'b0;
        axi.araddr  = 32'h0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = 32'h0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;
        addr_ok     = 1'b0;
        data_ok     = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = wr ? S_AW : S_AR;
            end
            S_AR: begin
                axi.arvalid = 1'b1;
                axi.araddr  = bus_addr;
                addr_ok     = axi.arready;
                if (axi.arready) state_d = S_R;
            end
            S_R: begin
                axi.rready = 1'b1;
                data_ok    = axi.rvalid;
                if (axi.rvalid && axi.rlast) begin
                    done    = 1'b1;
                    err     = err_q | axi.rresp[1];
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                axi.awvalid = 1'b1;
                axi.awaddr  = bus_addr;
                addr_ok     = axi.awready;
                if (axi.awready) state_d = S_W;
            end
            S_W: begin
                axi.wvalid = 1'b1;
                axi.wlast  = (cnt_q == last_beat);
                data_ok    = axi.wready;
                if (axi.wready && axi.wlast) state_d = S_B;
            end
            S_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    done    = 1'b1;
                    err     = err_q | axi.bresp[1];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, beat counter and sticky response-error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= 32'h0;
            unc_q   <= 1'b0;
            strb_q  <= 4'h0;
            start_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                unc_q   <= uncached;
                strb_q  <= wstrb_in;
                start_q <= addr[CW+1:2];
                err_q   <= 1'b0;
            end
            if (addr_ok) begin
                cnt_q <= '0;
            end else if (data_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_R && axi.rvalid) err_q <= err_q | axi.rresp[1];
            if (state_q == S_B && axi.bvalid) err_q <= err_q | axi.bresp[1];
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: a 16-word-line read port and an
// 8-word-line write port share cache-side stimulus; expectations follow
// CACHE_AXI_WRAP_EN when it is defined.
module tb_cache_axi_bridge;

`ifdef CACHE_AXI_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req16, req8, wr, uncached;
    logic [31:0] addr, wdata_in;
    logic [3:0]  wstrb_in;

    logic [31:0] rdata16, rdata8;
    logic [3:0]  bidx16;
    logic [2:0]  bidx8;
    logic        aok16, dok16, done16, err16;
    logic        aok8, dok8, done8, err8;

    int errors = 0;
    int checks = 0;

    cache_axi_bridge_if ax16 ();
    cache_axi_bridge_if ax8 ();

    cache_axi_bridge #(.ID(1'b0), .LINE_WORDS(16)) dut16 (
        .clk(clk), .rstn(rstn), .req(req16), .wr(wr), .uncached(uncached),
        .addr(addr), .wstrb_in(wstrb_in), .wdata_in(wdata_in),
        .rdata_out(rdata16), .beat_idx(bidx16), .addr_ok(aok16),
        .data_ok(dok16), .done(done16), .err(err16), .axi(ax16.master)
    );

    cache_axi_bridge #(.ID(1'b0), .LINE_WORDS(8)) dut8 (
        .clk(clk), .rstn(rstn), .req(req8), .wr(wr), .uncached(uncached),
        .addr(addr), .wstrb_in(wstrb_in), .wdata_in(wdata_in),
        .rdata_out(rdata8), .beat_idx(bidx8), .addr_ok(aok8),
        .data_ok(dok8), .done(done8), .err(err8), .axi(ax8.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int beats;
        logic [31:0] exp_idx;

        req16 = 1'b0; req8 = 1'b0; wr = 1'b0; uncached = 1'b0;
        addr = 32'h0; wdata_in = 32'h0; wstrb_in = 4'h0;
        ax16.arready = 1'b0; ax16.rid = 4'h0; ax16.rdata = 32'h0; ax16.rresp = 2'b00;
        ax16.rlast = 1'b0; ax16.rvalid = 1'b0; ax16.awready = 1'b0; ax16.wready = 1'b0;
        ax16.bid = 4'h0; ax16.bresp = 2'b00; ax16.bvalid = 1'b0;
        ax8.arready = 1'b0; ax8.rid = 4'h0; ax8.rdata = 32'h0; ax8.rresp = 2'b00;
        ax8.rlast = 1'b0; ax8.rvalid = 1'b0; ax8.awready = 1'b0; ax8.wready = 1'b0;
        ax8.bid = 4'h0; ax8.bresp = 2'b00; ax8.bvalid = 1'b0;

        // Reset values
        #2;
        check("rst_arvalid", 32'(ax16.arvalid), 32'h0);
        check("rst_rready", 32'(ax16.rready), 32'h0);
        check("rst_araddr", ax16.araddr, 32'h0);
        check("rst_awvalid", 32'(ax8.awvalid), 32'h0);
        check("rst_wvalid", 32'(ax8.wvalid), 32'h0);
        check("rst_bready", 32'(ax8.bready), 32'h0);
        check("rst_flags16", {28'h0, aok16, dok16, done16, err16}, 32'h0);
        check("rst_flags8", {28'h0, aok8, dok8, done8, err8}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Cached 16-word read from 0x1000_0024
        req16 = 1'b1; wr = 1'b0; uncached = 1'b0; addr = 32'h1000_0024;
        #1 check("rd_arvalid_latency", 32'(ax16.arvalid), 32'h0);
        @(negedge clk);
        check("rd_arvalid", 32'(ax16.arvalid), 32'h1);
        check("rd_araddr", ax16.araddr, WRAP ? 32'h1000_0024 : 32'h1000_0000);
        check("rd_arlen", 32'(ax16.arlen), 32'd15);
        check("rd_arburst", 32'(ax16.arburst), WRAP ? 32'h2 : 32'h1);
        check("rd_arsize", 32'(ax16.arsize), 32'h2);
        check("rd_arid_prot", {24'h0, ax16.arid, 1'b0, ax16.arprot}, 32'h0);
        ax16.arready = 1'b1;
        #1 check("rd_addr_ok", 32'(aok16), 32'h1);
        @(negedge clk);
        req16 = 1'b0; ax16.arready = 1'b0;
        #1 check("rd_araddr_idle", ax16.araddr, 32'h0);
        check("rd_rready", 32'(ax16.rready), 32'h1);
        for (int i = 0; i < 16; i++) begin
            ax16.rvalid = 1'b1; ax16.rdata = 32'hA000_0000 + i;
            ax16.rlast = (i == 15); ax16.rresp = 2'b00;
            exp_idx = WRAP ? ((9 + i) % 16) : i;
            #1 check("rd_data_ok", 32'(dok16), 32'h1);
            check("rd_beat_idx", 32'(bidx16), exp_idx);
            check("rd_rdata_out", rdata16, 32'hA000_0000 + i);
            check("rd_done", 32'(done16), (i == 15) ? 32'h1 : 32'h0);
            if (i == 15) check("rd_err", 32'(err16), 32'h0);
            @(negedge clk);
        end
        ax16.rvalid = 1'b0; ax16.rlast = 1'b0;
        #1 check("rd_rready_after", 32'(ax16.rready), 32'h0);
        @(negedge clk);

        // Uncached single-beat write with byte strobes and a SLVERR response
        req8 = 1'b1; wr = 1'b1; uncached = 1'b1; addr = 32'h3000_0006; wstrb_in = 4'b0011;
        @(negedge clk);
        check("uw_awvalid", 32'(ax8.awvalid), 32'h1);
        check("uw_awaddr", ax8.awaddr, 32'h3000_0006);
        check("uw_awlen", 32'(ax8.awlen), 32'h0);
        check("uw_awburst", 32'(ax8.awburst), 32'h1);
        ax8.awready = 1'b1;
        #1 check("uw_addr_ok", 32'(aok8), 32'h1);
        @(negedge clk);
        req8 = 1'b0; ax8.awready = 1'b0; wstrb_in = 4'h0;
        wdata_in = 32'hCAFE_0001; ax8.wready = 1'b1;
        #1 check("uw_wvalid", 32'(ax8.wvalid), 32'h1);
        check("uw_wstrb", 32'(ax8.wstrb), 32'h3);
        check("uw_wlast", 32'(ax8.wlast), 32'h1);
        check("uw_wdata", ax8.wdata, 32'hCAFE_0001);
        check("uw_beat_idx", 32'(bidx8), 32'h0);
        check("uw_data_ok", 32'(dok8), 32'h1);
        @(negedge clk);
        ax8.wready = 1'b0;
        #1 check("uw_bready", 32'(ax8.bready), 32'h1);
        check("uw_wvalid_off", 32'(ax8.wvalid), 32'h0);
        check("uw_done_early", 32'(done8), 32'h0);
        ax8.bvalid = 1'b1; ax8.bresp = 2'b10;
        #1 check("uw_done", 32'(done8), 32'h1);
        check("uw_err", 32'(err8), 32'h1);
        @(negedge clk);
        ax8.bvalid = 1'b0; ax8.bresp = 2'b00;
        #1 check("uw_bready_after", 32'(ax8.bready), 32'h0);
        @(negedge clk);

        // Cached 8-word write-back from 0x2000_0014 with wready toggling
        req8 = 1'b1; wr = 1'b1; uncached = 1'b0; addr = 32'h2000_0014;
        @(negedge clk);
        check("cw_awaddr", ax8.awaddr, WRAP ? 32'h2000_0014 : 32'h2000_0000);
        check("cw_awlen", 32'(ax8.awlen), 32'd7);
        check("cw_awburst", 32'(ax8.awburst), WRAP ? 32'h2 : 32'h1);
        ax8.awready = 1'b1;
        #1 check("cw_addr_ok", 32'(aok8), 32'h1);
        @(negedge clk);
        req8 = 1'b0; ax8.awready = 1'b0;
        beats = 0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            ax8.wready = c[0];
            exp_idx = WRAP ? ((5 + beats) % 8) : beats;
            wdata_in = 32'hB000_0000 + exp_idx;
            #1 check("cw_wvalid", 32'(ax8.wvalid), 32'h1);
            check("cw_wlast", 32'(ax8.wlast), (beats == 7) ? 32'h1 : 32'h0);
            check("cw_beat_idx", 32'(bidx8), exp_idx);
            check("cw_wstrb", 32'(ax8.wstrb), 32'hF);
            check("cw_data_ok", 32'(dok8), 32'(c[0]));
            if (c[0]) beats++;
            @(negedge clk);
        end
        ax8.wready = 1'b0;
        #1 check("cw_wvalid_off", 32'(ax8.wvalid), 32'h0);
        check("cw_bready", 32'(ax8.bready), 32'h1);
        ax8.bvalid = 1'b1; ax8.bresp = 2'b00;
        #1 check("cw_done", 32'(done8), 32'h1);
        check("cw_err_cleared", 32'(err8), 32'h0);
        @(negedge clk);
        ax8.bvalid = 1'b0;
        @(negedge clk);

        // Reset asserted during beat 5 of a cached read
        req16 = 1'b1; wr = 1'b0; uncached = 1'b0; addr = 32'h1000_0024;
        @(negedge clk);
        ax16.arready = 1'b1;
        @(negedge clk);
        req16 = 1'b0; ax16.arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ax16.rvalid = 1'b1; ax16.rlast = 1'b0;
            @(negedge clk);
        end
        rstn = 1'b0;
        #1 check("mr_rready", 32'(ax16.rready), 32'h0);
        check("mr_data_ok", 32'(dok16), 32'h0);
        check("mr_done", 32'(done16), 32'h0);
        check("mr_arvalid", 32'(ax16.arvalid), 32'h0);
        check("mr_beat_idx", 32'(bidx16), 32'h0);
        ax16.rvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Clean restart: short read ended early by rlast, error on beat 1
        req16 = 1'b1; addr = 32'h1000_0000;
        @(negedge clk);
        check("rs_araddr", ax16.araddr, 32'h1000_0000);
        ax16.arready = 1'b1;
        @(negedge clk);
        req16 = 1'b0; ax16.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ax16.rvalid = 1'b1; ax16.rlast = (i == 2);
            ax16.rresp = (i == 1) ? 2'b10 : 2'b00;
            #1 check("rs_beat_idx", 32'(bidx16), i);
            check("rs_done", 32'(done16), (i == 2) ? 32'h1 : 32'h0);
            if (i == 2) check("rs_err_sticky", 32'(err16), 32'h1);
            @(negedge clk);
        end
        ax16.rvalid = 1'b0; ax16.rlast = 1'b0; ax16.rresp = 2'b00;
        #1 check("rs_rready_after", 32'(ax16.rready), 32'h0);
        @(negedge clk);

        // Uncached single-beat read, error flag cleared from previous read
        req16 = 1'b1; uncached = 1'b1; addr = 32'h4000_0008;
        @(negedge clk);
        check("ur_araddr", ax16.araddr, 32'h4000_0008);
        check("ur_arlen", 32'(ax16.arlen), 32'h0);
        check("ur_arburst", 32'(ax16.arburst), 32'h1);
        ax16.arready = 1'b1;
        @(negedge clk);
        req16 = 1'b0; ax16.arready = 1'b0;
        ax16.rvalid = 1'b1; ax16.rlast = 1'b1; ax16.rdata = 32'h1234_5678;
        #1 check("ur_beat_idx", 32'(bidx16), 32'h0);
        check("ur_done", 32'(done16), 32'h1);
        check("ur_err", 32'(err16), 32'h0);
        check("ur_rdata_out", rdata16, 32'h1234_5678);
        @(negedge clk);
        ax16.rvalid = 1'b0; ax16.rlast = 1'b0;
        #1 check("ur_idle", 32'(ax16.rready), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
